// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the MIPS control/datapath and the multiply/divide unit.
// The master drives requests and MTHI/MTLO writes; the slave returns status and the HI/LO registers.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then applies sign correction in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               zero_div;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes for signed ops, one iteration step of each algorithm, and the final sign fix-up.
  always_comb begin
    abs_a     = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix   = zero_div ? '1 : (neg_lo ? -acc_lo : acc_lo);
    rem_fix   = neg_hi ? -acc_hi : acc_hi;
  end

  // Divide keeps the dividend in acc_lo and the divisor in opnd; multiply keeps the multiplier
  // in acc_lo and the multiplicand in opnd, so both shift through the same register pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      zero_div <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            state    <= RUN;
            busy_q   <= 1'b1;
            cnt      <= '0;
            dbz_q    <= 1'b0;
            is_div   <= bus.op[1];
            neg_lo   <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi   <= bus.op[0] & bus.op[1] & bus.a[WIDTH-1];
            zero_div <= bus.op[1] & (bus.b == '0);
            acc_hi   <= '0;
            acc_lo   <= bus.op[1] ? abs_a : abs_b;
            opnd     <= bus.op[1] ? abs_b : abs_a;
          end
        end
        RUN: begin
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIN;
        end
        FIN: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          dbz_q  <= zero_div;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a transaction-level model predicts busy/done/hi/lo/div_by_zero
// every cycle, with directed literal checks on known results and random operations on top.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: architectural HI/LO plus a countdown to the pending result
  logic         m_busy;
  logic         m_done;
  logic         m_dbz;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic [W-1:0] p_hi;
  logic [W-1:0] p_lo;
  logic         p_dbz;
  int           m_left;

  // Results from plain 64-bit arithmetic; DIV relies on SV truncating division toward zero
  function automatic void modelOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
    longint     sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      OP_MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      OP_MULT: begin
        p = 64'(sx * sy);
        rh = p[63:32];
        rl = p[31:0];
      end
      default: begin
        if (y == '0) begin
          rl = '1;
          rh = x;
          rz = 1'b1;
        end else if (o == OP_DIVU) begin
          rl = x / y;
          rh = x % y;
        end else begin
          q = sx / sy;
          r = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
    endcase
  endfunction

  // Advance the model one clock edge using the inputs as the DUT sees them
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
        if (bus.start) begin
          modelOp(bus.op, bus.a, bus.b, p_hi, p_lo, p_dbz);
          m_dbz  = 1'b0;
          m_busy = 1'b1;
          m_left = W + 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_dbz  = p_dbz;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle the model is the reference for all outputs
  always @(negedge clk) begin
    checkOutput("busy", W'(bus.busy), W'(m_busy));
    checkOutput("done", W'(bus.done), W'(m_done));
    checkOutput("div_by_zero", W'(bus.div_by_zero), W'(m_dbz));
    checkOutput("hi", bus.hi, m_hi);
    checkOutput("lo", bus.lo, m_lo);
  end

  // Drive one start at a negedge, then scramble operands so late changes would show up
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic hw, input logic lw, input logic [W-1:0] wd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.wdata = $urandom;
  endtask

  // Counts busy cycles seen until done; ends at the negedge inside the done cycle
  task automatic waitDone(output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) n++;
      @(negedge clk);
    end
    if (!bus.done) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", W'(bus.busy), '0);
    checkOutput("reset_hi", bus.hi, '0);
    #2 rst_n = 1'b1;

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    waitDone(n);
    checkOutput("multu_busy_cycles", W'(n), 32'd33);
    checkOutput("multu_hi", bus.hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", bus.lo, 32'h0000_0001);
    @(negedge clk);
    checkOutput("done_width", W'(bus.done), '0);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0);
    waitDone(n);
    checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFF_FFF1);

    // New operands pulsed mid-operation must not disturb the DIVU in flight
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(n);
    checkOutput("divu_lo", bus.lo, 32'd14);
    checkOutput("divu_hi", bus.hi, 32'd2);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
    waitDone(n);
    checkOutput("div_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", bus.hi, 32'hFFFF_FFFF);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    waitDone(n);
    checkOutput("div_ovf_lo", bus.lo, 32'h8000_0000);
    checkOutput("div_ovf_hi", bus.hi, '0);

    applyStimulus(OP_DIVU, 32'h0000_1234, '0, 1'b0, 1'b0, '0);
    waitDone(n);
    checkOutput("dbz_lo", bus.lo, 32'hFFFF_FFFF);
    checkOutput("dbz_hi", bus.hi, 32'h0000_1234);
    checkOutput("dbz_flag", W'(bus.div_by_zero), 32'd1);

    applyStimulus(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, '0);
    checkOutput("dbz_cleared", W'(bus.div_by_zero), '0);
    waitDone(n);
    checkOutput("small_hi", bus.hi, '0);
    checkOutput("small_lo", bus.lo, 32'd6);

    // Start raised inside the done cycle is accepted on the following edge
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd7;
    bus.b     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(n);
    checkOutput("b2b_busy_cycles", W'(n), 32'd33);
    checkOutput("b2b_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("b2b_lo", bus.lo, 32'hFFFF_FFF9);

    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1111;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checkOutput("mthi_idle", bus.hi, 32'h0000_1111);
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, '0);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checkOutput("mthi_busy_ignored", bus.hi, 32'h0000_1111);
    waitDone(n);
    checkOutput("mthi_overwritten", bus.hi, '0);

    // Reset in the middle of a MULT aborts it
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 1'b0, '0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", W'(bus.busy), '0);
    checkOutput("rst_hi", bus.hi, '0);
    checkOutput("rst_lo", bus.lo, '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_00A5;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checkOutput("mtlo_after_reset", bus.lo, 32'h0000_00A5);
    checkOutput("no_done_after_abort", W'(bus.done), '0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), pick(), pick(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      waitDone(n);
      if ($urandom_range(0, 1) == 1) begin
        bus.hi_we = 1'($urandom_range(0, 1));
        bus.lo_we = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
